// File: rtl/riscv_pipeline_pkg.sv
// Shared pipeline constants: bubble instruction, default widths and the
// occupancy encoding of the IF/ID skid register.
package riscv_pipeline_pkg;

  localparam int          DEFAULT_XLEN        = 32;
  localparam int          DEFAULT_INSTR_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at its maximum value; a synchronous clear wins
// over an increment in the same cycle.
module saturating_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr_i) begin
      count_next = '0;
    end else if (inc_i && (count_reg != {WIDTH{1'b1}})) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count_o = count_reg;

endmodule

// File: rtl/if_id_skid_register.sv
// IF/ID pipeline register with a two-entry skid buffer: ready_o depends only
// on stored occupancy, so decode stalls never reach fetch combinationally.
module if_id_skid_register #(
  parameter int                     XLEN        = riscv_pipeline_pkg::DEFAULT_XLEN,
  parameter int                     INSTR_WIDTH = riscv_pipeline_pkg::DEFAULT_INSTR_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(riscv_pipeline_pkg::NOP_INSTR),
  parameter int                     CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [INSTR_WIDTH-1:0] instruction_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic                   flush_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic [XLEN-1:0]        pc_o,
  input  logic                   clear_counters_i,
  output logic [CNT_WIDTH-1:0]   stall_cycles_o,
  output logic [CNT_WIDTH-1:0]   flush_count_o
);

  import riscv_pipeline_pkg::*;

  occ_e                   occ_reg,        occ_next;
  logic [INSTR_WIDTH-1:0] main_instr_reg, main_instr_next;
  logic [XLEN-1:0]        main_pc_reg,    main_pc_next;
  logic [INSTR_WIDTH-1:0] skid_instr_reg, skid_instr_next;
  logic [XLEN-1:0]        skid_pc_reg,    skid_pc_next;

  logic accept;
  logic fire;

  assign valid_o       = (occ_reg != OCC_EMPTY);
  assign ready_o       = (occ_reg != OCC_TWO);
  assign instruction_o = main_instr_reg;
  assign pc_o          = main_pc_reg;

  assign accept = valid_i & ready_o;
  assign fire   = valid_o & ready_i;

  always_comb begin
    occ_next        = occ_reg;
    main_instr_next = main_instr_reg;
    main_pc_next    = main_pc_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;

    if (flush_i) begin
      // Redirect: drop everything held or offered, park a bubble at the redirect PC.
      occ_next        = OCC_EMPTY;
      main_instr_next = NOP_INSTR;
      main_pc_next    = pc_i;
    end else begin
      unique case (occ_reg)
        OCC_EMPTY: begin
          if (accept) begin
            occ_next        = OCC_ONE;
            main_instr_next = instruction_i;
            main_pc_next    = pc_i;
          end
        end
        OCC_ONE: begin
          if (fire && accept) begin
            main_instr_next = instruction_i;
            main_pc_next    = pc_i;
          end else if (fire) begin
            occ_next = OCC_EMPTY;
          end else if (accept) begin
            occ_next        = OCC_TWO;
            skid_instr_next = instruction_i;
            skid_pc_next    = pc_i;
          end
        end
        OCC_TWO: begin
          if (fire) begin
            occ_next        = OCC_ONE;
            main_instr_next = skid_instr_reg;
            main_pc_next    = skid_pc_reg;
          end
        end
        default: occ_next = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_reg        <= OCC_EMPTY;
      main_instr_reg <= '0;
      main_pc_reg    <= '0;
      skid_instr_reg <= '0;
      skid_pc_reg    <= '0;
    end else begin
      occ_reg        <= occ_next;
      main_instr_reg <= main_instr_next;
      main_pc_reg    <= main_pc_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
    end
  end

  saturating_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (valid_o & ~ready_i & ~flush_i),
    .clr_i   (clear_counters_i),
    .count_o (stall_cycles_o)
  );

  saturating_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_flush_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (flush_i),
    .clr_i   (clear_counters_i),
    .count_o (flush_count_o)
  );

endmodule

// File: tb/tb_if_id_skid_register.sv
// Self-checking bench for if_id_skid_register: directed vector table, corner
// sequences (saturation, async reset) and a queue-based random reference model.
module tb_if_id_skid_register;

  localparam int          CW   = 4;
  localparam int          CMAX = 15;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            valid_i;
  logic            ready_o;
  logic [31:0]     instruction_i;
  logic [31:0]     pc_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [31:0]     instruction_o;
  logic [31:0]     pc_o;
  logic            clear_counters_i;
  logic [CW-1:0]   stall_cycles_o;
  logic [CW-1:0]   flush_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_skid_register #(
    .XLEN        (32),
    .INSTR_WIDTH (32),
    .NOP_INSTR   (NOP),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .instruction_i    (instruction_i),
    .pc_i             (pc_i),
    .flush_i          (flush_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .instruction_o    (instruction_o),
    .pc_o             (pc_o),
    .clear_counters_i (clear_counters_i),
    .stall_cycles_o   (stall_cycles_o),
    .flush_count_o    (flush_count_o)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        fl;
    logic        clr;
    logic        ev;
    logic        erdy;
    logic [31:0] epc;
    logic [31:0] einstr;
    int          est;
    int          efl;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  vec_t vq[$];

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] pc, input logic rdy, input logic fl,
                     input logic clr, input logic ev, input logic erdy, input logic [31:0] epc,
                     input logic [31:0] einstr, input int est, input int efl);
    vec_t t;
    t.v = v; t.pc = pc; t.rdy = rdy; t.fl = fl; t.clr = clr;
    t.ev = ev; t.erdy = erdy; t.epc = epc; t.einstr = einstr; t.est = est; t.efl = efl;
    vq.push_back(t);
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic rdy, input logic fl, input logic clr);
    valid_i          = v;
    pc_i             = pc;
    instruction_i    = instr;
    ready_i          = rdy;
    flush_i          = fl;
    clear_counters_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic erdy, input logic [31:0] epc,
                         input logic [31:0] einstr, input int est, input int efl);
    chk({tag, ".valid_o"}, 64'(valid_o), 64'(ev));
    chk({tag, ".ready_o"}, 64'(ready_o), 64'(erdy));
    chk({tag, ".pc_o"}, 64'(pc_o), 64'(epc));
    chk({tag, ".instruction_o"}, 64'(instruction_o), 64'(einstr));
    chk({tag, ".stall_cycles_o"}, 64'(stall_cycles_o), 64'(est));
    chk({tag, ".flush_count_o"}, 64'(flush_count_o), 64'(efl));
  endtask

  initial begin
    item_t       q[$];
    item_t       it;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    int          m_st;
    int          m_fl;
    logic        m_valid;
    logic        m_ready;
    logic        rv, rr, rf, rc;
    logic [31:0] rpc, rins;

    reset_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_all("reset", 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);
    reset_n = 1'b1;

    // Stream, backpressure, flush in TWO, flush with valid, back-to-back flush, clears.
    add(1, 32'h00, 1, 0, 0,  1, 1, 32'h00, mk(32'h00), 0, 0);
    add(1, 32'h04, 1, 0, 0,  1, 1, 32'h04, mk(32'h04), 0, 0);
    add(1, 32'h08, 1, 0, 0,  1, 1, 32'h08, mk(32'h08), 0, 0);
    add(0, 32'h00, 1, 0, 0,  0, 1, 32'h08, mk(32'h08), 0, 0);
    add(1, 32'h10, 1, 0, 0,  1, 1, 32'h10, mk(32'h10), 0, 0);
    add(1, 32'h14, 0, 0, 0,  1, 0, 32'h10, mk(32'h10), 1, 0);
    add(1, 32'h18, 0, 0, 0,  1, 0, 32'h10, mk(32'h10), 2, 0);
    add(0, 32'h00, 1, 0, 0,  1, 1, 32'h14, mk(32'h14), 2, 0);
    add(0, 32'h00, 1, 0, 0,  0, 1, 32'h14, mk(32'h14), 2, 0);
    add(1, 32'h20, 0, 0, 0,  1, 1, 32'h20, mk(32'h20), 2, 0);
    add(1, 32'h24, 0, 0, 0,  1, 0, 32'h20, mk(32'h20), 3, 0);
    add(0, 32'h80, 0, 1, 0,  0, 1, 32'h80, NOP,        3, 1);
    add(0, 32'h00, 1, 0, 0,  0, 1, 32'h80, NOP,        3, 1);
    add(1, 32'h40, 1, 1, 0,  0, 1, 32'h40, NOP,        3, 2);
    add(1, 32'h44, 1, 0, 0,  1, 1, 32'h44, mk(32'h44), 3, 2);
    add(0, 32'h00, 0, 0, 0,  1, 1, 32'h44, mk(32'h44), 4, 2);
    add(0, 32'h00, 1, 0, 0,  0, 1, 32'h44, mk(32'h44), 4, 2);
    add(1, 32'h50, 1, 1, 0,  0, 1, 32'h50, NOP,        4, 3);
    add(1, 32'h54, 1, 1, 0,  0, 1, 32'h54, NOP,        4, 4);
    add(0, 32'h00, 1, 0, 1,  0, 1, 32'h54, NOP,        0, 0);
    add(0, 32'h60, 0, 1, 1,  0, 1, 32'h60, NOP,        0, 0);

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].pc, mk(vq[i].pc), vq[i].rdy, vq[i].fl, vq[i].clr);
      $display("vec %0d: valid_i=%0b pc_i=%0h ready_i=%0b flush=%0b clr=%0b -> valid_o=%0b ready_o=%0b pc_o=%0h",
               i, vq[i].v, vq[i].pc, vq[i].rdy, vq[i].fl, vq[i].clr, valid_o, ready_o, pc_o);
      chk_all($sformatf("vec%0d", i), vq[i].ev, vq[i].erdy, vq[i].epc, vq[i].einstr,
              vq[i].est, vq[i].efl);
    end

    // Stall counter saturation, then clear during a stall cycle.
    drive(1'b1, 32'h100, mk(32'h100), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (i == 13) chk("sat.stall14", 64'(stall_cycles_o), 64'd14);
      if (i == 14) chk("sat.stall15", 64'(stall_cycles_o), 64'd15);
    end
    $display("saturation: stall_cycles_o=%0d after 20 stalled cycles", stall_cycles_o);
    chk_all("sat.end", 1'b1, 1'b1, 32'h100, mk(32'h100), 15, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_all("sat.clear", 1'b1, 1'b1, 32'h100, mk(32'h100), 0, 0);

    // Fill to TWO, then assert reset asynchronously in the middle of a stall.
    drive(1'b1, 32'h104, mk(32'h104), 1'b0, 1'b0, 1'b0);
    chk_all("two", 1'b1, 1'b0, 32'h100, mk(32'h100), 1, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset: valid_o=%0b ready_o=%0b pc_o=%0h", valid_o, ready_o, pc_o);
    chk_all("areset.now", 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("areset.held", 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_all("areset.after", 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);

    // Random traffic against a queue model of the two-deep buffer.
    m_instr = 32'h0;
    m_pc    = 32'h0;
    m_st    = 0;
    m_fl    = 0;
    for (int n = 0; n < 2000; n++) begin
      rv   = ($urandom_range(0, 9) < 7);
      rr   = ($urandom_range(0, 9) < 6);
      rf   = ($urandom_range(0, 19) == 0);
      rc   = ($urandom_range(0, 49) == 0);
      rpc  = $urandom;
      rins = $urandom;
      m_valid = (q.size() > 0);
      m_ready = (q.size() < 2);
      drive(rv, rpc, rins, rr, rf, rc);

      if (rc) m_st = 0;
      else if (m_valid && !rr && !rf && m_st < CMAX) m_st++;
      if (rc) m_fl = 0;
      else if (rf && m_fl < CMAX) m_fl++;

      if (rf) begin
        q.delete();
        m_instr = NOP;
        m_pc    = rpc;
      end else begin
        if (m_valid && rr) void'(q.pop_front());
        if (rv && m_ready) begin
          it.instr = rins;
          it.pc    = rpc;
          q.push_back(it);
        end
        if (q.size() > 0) begin
          m_instr = q[0].instr;
          m_pc    = q[0].pc;
        end
      end
      chk_all($sformatf("rand%0d", n), (q.size() > 0), (q.size() < 2), m_pc, m_instr, m_st, m_fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
